// File: rtl/sipo_deser_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : sipo_pkg                                                        |
// | Purpose  : Shared types and constants for the sipo_deser receiver.         |
// |            Holds the receive-FSM state encoding, the parity polarity and   |
// |            a helper that sizes the bit counter from the word width.        |
// | Options  : SIPO_DESER_PARITY_EN (consumed by sipo_deser / sipo_deser_if)   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package sipo_pkg;

  // Receive FSM states: data bits, then (optionally) one parity bit.
  typedef enum logic [0:0] {
    RX_DATA = 1'b0,
    RX_PAR  = 1'b1
  } rx_state_t;

  // Even parity: XOR over word and parity bit is 0 for a clean frame.
  localparam logic PAR_EVEN     = 1'b0;
  localparam logic PAR_POLARITY = PAR_EVEN;

  // Bit counter width; must be able to hold the value WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage : sipo_pkg
`default_nettype wire

// File: rtl/sipo_deser_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface: sipo_deser_if                                                   |
// | Purpose  : Serial input, frame restart and word output handshake of the   |
// |            SIPO deserializer bundled into one port.                        |
// |            master  = link/downstream side (drives sin, consumes pout)      |
// |            slave   = the deserializer itself                               |
// | Options  : SIPO_DESER_PARITY_EN adds parity_err                            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface sipo_deser_if #(
  parameter int WIDTH = 4
);
  import sipo_pkg::*;

  localparam int CNT_W = cnt_width(WIDTH);

  // Serial side and frame control
  logic             clr;
  logic             sin;
  logic             sin_valid;

  // Word side
  logic [WIDTH-1:0] pout;
  logic             pout_valid;
  logic             pout_ready;

  // Status
  logic             overrun;
  logic [CNT_W-1:0] bit_cnt;

`ifdef SIPO_DESER_PARITY_EN
  logic             parity_err;

  modport master (
    output clr, sin, sin_valid, pout_ready,
    input  pout, pout_valid, overrun, bit_cnt, parity_err
  );

  modport slave (
    input  clr, sin, sin_valid, pout_ready,
    output pout, pout_valid, overrun, bit_cnt, parity_err
  );
`else
  modport master (
    output clr, sin, sin_valid, pout_ready,
    input  pout, pout_valid, overrun, bit_cnt
  );

  modport slave (
    input  clr, sin, sin_valid, pout_ready,
    output pout, pout_valid, overrun, bit_cnt
  );
`endif

endinterface : sipo_deser_if
`default_nettype wire

// File: rtl/sipo_deser.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sipo_deser                                                      |
// | Purpose  : Serial-in parallel-out deserializer, receive end of the PISO    |
// |            shift link. Bits arrive LSB first, one per sin_valid strobe,    |
// |            and are assembled into WIDTH-bit words offered on a             |
// |            valid/ready port backed by a single holding register.          |
// |            A word completing while the holding register is still full and  |
// |            not being drained is dropped and flagged in sticky overrun.     |
// | Options  : SIPO_DESER_PARITY_EN - one even-parity bit follows each word;   |
// |            completion moves to the parity bit and parity_err is reported   |
// |            alongside pout.                                                 |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  sipo_deser_if.slave   bus
);

  localparam int CNT_W = cnt_width(WIDTH);

  // Count value carried by the final data bit of a word.
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // ---------------------------------------------------------------------------
  // Receive path state
  // ---------------------------------------------------------------------------
  rx_state_t        state;
  rx_state_t        state_nxt;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  // Completion event and the word it carries, valid only while word_done=1.
  logic             word_done;
  logic [WIDTH-1:0] word;

  // ---------------------------------------------------------------------------
  // Holding register / output handshake state
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] hold;
  logic             hold_valid;
  logic             ovr;
  logic             xfer;
  logic             can_load;

`ifdef SIPO_DESER_PARITY_EN
  logic             word_perr;
  logic             perr;
`endif

  // Receive state, shift register and bit counter; reset discards any partial word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RX_DATA;
      sreg  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      sreg  <= sreg_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state decode: clr restarts the frame ahead of any strobe, data bits shift
  // in from the top so the first bit received lands in bit 0 after WIDTH shifts.
  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg;
    cnt_nxt   = cnt;
    word_done = 1'b0;
    word      = sreg;
`ifdef SIPO_DESER_PARITY_EN
    word_perr = 1'b0;
`endif

    if (bus.clr) begin
      state_nxt = RX_DATA;
      sreg_nxt  = '0;
      cnt_nxt   = '0;
    end else if (bus.sin_valid) begin
      case (state)
        RX_DATA: begin
          sreg_nxt = {bus.sin, sreg[WIDTH-1:1]};
          if (cnt == LAST_DATA) begin
`ifdef SIPO_DESER_PARITY_EN
            // Word is assembled but only released once its parity bit arrives.
            cnt_nxt   = cnt + CNT_ONE;
            state_nxt = RX_PAR;
`else
            cnt_nxt   = '0;
            word_done = 1'b1;
            word      = {bus.sin, sreg[WIDTH-1:1]};
`endif
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end

        RX_PAR: begin
`ifdef SIPO_DESER_PARITY_EN
          // sreg already holds the full word; this strobe carries the parity bit.
          cnt_nxt   = '0;
          state_nxt = RX_DATA;
          word_done = 1'b1;
          word      = sreg;
          word_perr = (^{sreg, bus.sin}) ^ PAR_POLARITY;
`else
          state_nxt = RX_DATA;
`endif
        end

        default: begin
          state_nxt = RX_DATA;
        end
      endcase
    end
  end

  // A handshake completes when the holder is full and downstream is ready;
  // a new word may be accepted when the holder is empty or draining this cycle.
  assign xfer     = hold_valid && bus.pout_ready;
  assign can_load = !hold_valid || bus.pout_ready;

  // Holding register: load on completion if space, otherwise drop and flag overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold       <= '0;
      hold_valid <= 1'b0;
      ovr        <= 1'b0;
`ifdef SIPO_DESER_PARITY_EN
      perr       <= 1'b0;
`endif
    end else begin
      if (word_done) begin
        if (can_load) begin
          hold       <= word;
          hold_valid <= 1'b1;
`ifdef SIPO_DESER_PARITY_EN
          perr       <= word_perr;
`endif
        end else begin
          ovr <= 1'b1;
        end
      end else if (xfer) begin
        hold_valid <= 1'b0;
      end

      // A frame restart also clears the sticky overrun flag; word_done is
      // already suppressed under clr so the two never race.
      if (bus.clr) begin
        ovr <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output drive
  // ---------------------------------------------------------------------------
  assign bus.pout       = hold;
  assign bus.pout_valid = hold_valid;
  assign bus.overrun    = ovr;
  assign bus.bit_cnt    = cnt;
`ifdef SIPO_DESER_PARITY_EN
  assign bus.parity_err = perr;
`endif

endmodule : sipo_deser
`default_nettype wire

// File: tb/tb_sipo_deser.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_sipo_deser                                                   |
// | Purpose  : Self-checking bench for sipo_deser (WIDTH=4). Directed scenarios |
// |            followed by randomized traffic, all compared every cycle with   |
// |            a frame-level reference model (bit list -> integer word).       |
// | Options  : SIPO_DESER_PARITY_EN enables parity frames and checks           |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_sipo_deser;

  localparam int WIDTH = 4;
`ifdef SIPO_DESER_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  sipo_deser_if #(.WIDTH(WIDTH)) bus ();

  sipo_deser #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: bits received so far in the frame, and the offered word.
  int m_nbits;
  int m_acc;
  int m_pout;
  bit m_valid;
  bit m_ovr;
  bit m_perr;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_nbits = 0;
    m_acc   = 0;
    m_pout  = 0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_perr  = 1'b0;
  endtask

  // Frame-level model: data bit k has weight 2**k; the word is released after
  // FRAME strobes; parity error = odd number of ones across word plus parity.
  task automatic model_step(input bit c, input bit v, input bit s, input bit r);
    bit done;
    bit perr_new;
    done     = 1'b0;
    perr_new = 1'b0;
    if (c) begin
      m_nbits = 0;
      m_acc   = 0;
      m_ovr   = 1'b0;
    end else if (v) begin
      if (m_nbits < WIDTH) m_acc = m_acc + (int'(s) << m_nbits);
      else                 perr_new = (($countones(m_acc) + int'(s)) % 2) == 1;
      m_nbits++;
      if (m_nbits == FRAME) begin
        done    = 1'b1;
        m_nbits = 0;
      end
    end
    if (done) begin
      if (!m_valid || r) begin
        m_pout  = m_acc;
        m_valid = 1'b1;
        m_perr  = perr_new;
      end else begin
        m_ovr = 1'b1;
      end
      m_acc = 0;
    end else if (m_valid && r) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic compare_all(input string tag);
    check_eq({tag, ".pout_valid"}, int'(bus.pout_valid), int'(m_valid));
    check_eq({tag, ".overrun"},    int'(bus.overrun),    int'(m_ovr));
    check_eq({tag, ".bit_cnt"},    int'(bus.bit_cnt),    m_nbits);
    if (m_valid) begin
      check_eq({tag, ".pout"}, int'(bus.pout), m_pout);
`ifdef SIPO_DESER_PARITY_EN
      check_eq({tag, ".parity_err"}, int'(bus.parity_err), int'(m_perr));
`endif
    end
  endtask

  // One clock: drive inputs, advance the model, sample 1 time unit after the edge.
  task automatic tick(input bit v, input bit s, input bit r, input bit c);
    bus.sin_valid  = v;
    bus.sin        = s;
    bus.pout_ready = r;
    bus.clr        = c;
    model_step(c, v, s, r);
    @(posedge clk);
    #1;
    compare_all("tick");
  endtask

  // Send one frame LSB first; r_last is the ready level on the completing strobe.
  task automatic send_frame(input logic [WIDTH-1:0] data, input bit par,
                            input bit r_body, input bit r_last);
    for (int i = 0; i < WIDTH; i++) begin
      tick(1'b1, data[i], (i == FRAME - 1) ? r_last : r_body, 1'b0);
    end
`ifdef SIPO_DESER_PARITY_EN
    tick(1'b1, par, r_last, 1'b0);
`else
    if (par) begin end
`endif
  endtask

  initial begin
    logic [WIDTH-1:0] d;
    bus.sin_valid  = 1'b0;
    bus.sin        = 1'b0;
    bus.pout_ready = 1'b0;
    bus.clr        = 1'b0;
    model_reset();

    // Power-on reset
    repeat (2) @(posedge clk);
    #1;
    check_eq("por.pout",       int'(bus.pout),       0);
    check_eq("por.pout_valid", int'(bus.pout_valid), 0);
    check_eq("por.overrun",    int'(bus.overrun),    0);
    check_eq("por.bit_cnt",    int'(bus.bit_cnt),    0);
    rst_n = 1'b1;

    // Basic word 1,0,1,1 -> 4'b1101, visible after the final strobe, drained next cycle
    d = 4'b1101;
    send_frame(d, ^d, 1'b1, 1'b1);
    check_eq("basic.pout",  int'(bus.pout),       13);
    check_eq("basic.valid", int'(bus.pout_valid), 1);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("basic.drained", int'(bus.pout_valid), 0);

    // Backpressure: 4'hA held, 4'h5 dropped, overrun sticky until clr
    d = 4'hA;
    send_frame(d, ^d, 1'b0, 1'b0);
    d = 4'h5;
    send_frame(d, ^d, 1'b0, 1'b0);
    check_eq("bp.pout",    int'(bus.pout),       10);
    check_eq("bp.overrun", int'(bus.overrun),    1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("bp.clr_overrun", int'(bus.overrun),    0);
    check_eq("bp.clr_valid",   int'(bus.pout_valid), 1);

    // Transfer and completion in the same cycle: new word loads, no overrun
    d = 4'h3;
    send_frame(d, ^d, 1'b0, 1'b1);
    check_eq("simul.pout",    int'(bus.pout),       3);
    check_eq("simul.valid",   int'(bus.pout_valid), 1);
    check_eq("simul.overrun", int'(bus.overrun),    0);
    tick(1'b0, 1'b0, 1'b1, 1'b0);

    // clr mid-word discards the two leading bits
    tick(1'b1, 1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b1);
    check_eq("clr.bit_cnt", int'(bus.bit_cnt), 0);
    d = 4'b0110;
    send_frame(d, ^d, 1'b1, 1'b1);
    check_eq("clr.pout", int'(bus.pout), 6);
    tick(1'b0, 1'b0, 1'b1, 1'b0);

    // Idle gaps between strobes do not change the result
    d = 4'b1101;
    for (int i = 0; i < FRAME; i++) begin
      tick(1'b0, 1'b1, 1'b1, 1'b0);
      tick(1'b1, (i < WIDTH) ? d[i] : ^d, 1'b1, 1'b0);
    end
    check_eq("gap.pout", int'(bus.pout), 13);
    tick(1'b0, 1'b0, 1'b1, 1'b0);

`ifdef SIPO_DESER_PARITY_EN
    // Parity: correct even parity bit, then a wrong one
    d = 4'b1101;
    send_frame(d, 1'b1, 1'b1, 1'b1);
    check_eq("par.ok_pout", int'(bus.pout),       13);
    check_eq("par.ok_err",  int'(bus.parity_err), 0);
    send_frame(d, 1'b0, 1'b1, 1'b1);
    check_eq("par.bad_err", int'(bus.parity_err), 1);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
`endif

    // Asynchronous reset mid-shift with a held word and overrun pending
    d = 4'h9;
    send_frame(d, ^d, 1'b0, 1'b0);
    d = 4'h6;
    send_frame(d, ^d, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    model_reset();
    check_eq("arst.pout",       int'(bus.pout),       0);
    check_eq("arst.pout_valid", int'(bus.pout_valid), 0);
    check_eq("arst.overrun",    int'(bus.overrun),    0);
    check_eq("arst.bit_cnt",    int'(bus.bit_cnt),    0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized traffic with backpressure and occasional restarts
    for (int n = 0; n < 800; n++) begin
      tick($urandom_range(0, 9) < 6, 1'($urandom), 1'($urandom),
           $urandom_range(0, 39) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_sipo_deser
`default_nettype wire
